// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the transmitter) and legal bit-period values.
`default_nettype none

package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   localparam int PRESCALE_8  = 8;
   localparam int PRESCALE_16 = 16;
   localparam int PRESCALE_32 = 32;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with a 2-of-3 majority vote around the bit centre.
`default_nettype none

module uart_rx_sampler #(
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_run,
   input  logic [PRESCALE_W-1:0] i_prescale,
   input  logic                  i_bit,
   output logic [PRESCALE_W-1:0] o_edge_cnt,
   output logic                  o_bit_done,
   output logic                  o_bit
);

   logic [PRESCALE_W-1:0] r_cnt;
   logic [2:0]            r_samp;
   logic [PRESCALE_W-1:0] w_half;

   assign w_half     = i_prescale >> 1;
   assign o_bit_done = i_run && (r_cnt == (i_prescale - PRESCALE_W'(1)));
   assign o_edge_cnt = r_cnt;
   assign o_bit      = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt  <= '0;
         r_samp <= '0;
      end else begin
         if (!i_run || o_bit_done) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + PRESCALE_W'(1);
         end
         if (i_run) begin
            if (r_cnt == w_half - PRESCALE_W'(1)) r_samp[0] <= i_bit;
            if (r_cnt == w_half)                  r_samp[1] <= i_bit;
            if (r_cnt == w_half + PRESCALE_W'(1)) r_samp[2] <= i_bit;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// UART receiver: synchronised serial input, oversampled framing, parity/stop checking, one-cycle outcome pulses.
`default_nettype none

module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] PRESCALE,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_W-1:0]     P_DATA,
   output logic                  DATA_VALID,
   output logic                  PAR_ERR,
   output logic                  STP_ERR
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   uart_state_t           r_state, w_next;
   logic                  r_sync1, r_sync2;
   logic [PRESCALE_W-1:0] r_prescale, w_prescale_eff;
   logic                  r_par_en, r_par_typ, r_par_bit;
   logic [DATA_W-1:0]     r_shift, r_pdata;
   logic [IDX_W-1:0]      r_bit_idx;
   logic                  r_valid, r_perr, r_serr;
   logic                  w_load, w_eval, w_par_bad, w_stp_bad;
   logic [PRESCALE_W-1:0] w_edge_cnt;
   logic                  w_bit_done, w_bit, w_unused_cnt;

   assign w_unused_cnt = ^w_edge_cnt;

   uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
      .clk        (clk),
      .reset      (reset),
      .i_run      (r_state != IDLE),
      .i_prescale (r_prescale),
      .i_bit      (r_sync2),
      .o_edge_cnt (w_edge_cnt),
      .o_bit_done (w_bit_done),
      .o_bit      (w_bit)
   );

   always_comb begin
      w_prescale_eff = PRESCALE_W'(PRESCALE_8);
      if (PRESCALE == PRESCALE_W'(PRESCALE_16) || PRESCALE == PRESCALE_W'(PRESCALE_32)) begin
         w_prescale_eff = PRESCALE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_state <= w_next;
         r_sync1 <= RX_IN;
         r_sync2 <= r_sync1;
      end
   end

   // A low line on the last stop cycle starts the next frame directly, so back-to-back frames keep their pitch.
   always_comb begin
      w_next    = r_state;
      w_eval    = 1'b0;
      w_par_bad = r_par_en && ((^r_shift ^ r_par_typ) != r_par_bit);
      w_stp_bad = !w_bit;
      case (r_state)
         IDLE:    if (!r_sync2) w_next = START;
         START:   if (w_bit_done) w_next = w_bit ? IDLE : DATA;
         DATA:    if (w_bit_done && r_bit_idx == IDX_W'(DATA_W-1)) w_next = r_par_en ? PARITY : STOP;
         PARITY:  if (w_bit_done) w_next = STOP;
         STOP: begin
            if (w_bit_done) begin
               w_eval = 1'b1;
               w_next = r_sync2 ? IDLE : START;
            end
         end
         default: w_next = IDLE;
      endcase
      w_load = (w_next == START) && (r_state != START);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prescale <= PRESCALE_W'(PRESCALE_8);
         r_par_en   <= 1'b0;
         r_par_typ  <= 1'b0;
         r_par_bit  <= 1'b0;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_pdata    <= '0;
         r_valid    <= 1'b0;
         r_perr     <= 1'b0;
         r_serr     <= 1'b0;
      end else begin
         r_valid <= w_eval && !w_par_bad && !w_stp_bad;
         r_perr  <= w_eval && w_par_bad;
         r_serr  <= w_eval && w_stp_bad;
         if (w_eval && !w_par_bad && !w_stp_bad) r_pdata <= r_shift;
         if (w_load) begin
            r_prescale <= w_prescale_eff;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_bit_idx  <= '0;
         end
         if (r_state == DATA && w_bit_done) begin
            r_shift   <= {w_bit, r_shift[DATA_W-1:1]};
            r_bit_idx <= r_bit_idx + IDX_W'(1);
         end
         if (r_state == PARITY && w_bit_done) r_par_bit <= w_bit;
      end
   end

   assign P_DATA     = r_pdata;
   assign DATA_VALID = r_valid;
   assign PAR_ERR    = r_perr;
   assign STP_ERR    = r_serr;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// Randomised frame-level bench for uart_rx with a behavioural outcome model and a per-cycle compare process.
`default_nettype none

module tb_uart_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       RX_IN;
   logic [5:0] PRESCALE;
   logic       PAR_EN, PAR_TYP;
   logic [7:0] P_DATA;
   logic       DATA_VALID, PAR_ERR, STP_ERR;

   uart_rx #(.DATA_W(8), .PRESCALE_W(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .RX_IN      (RX_IN),
      .PRESCALE   (PRESCALE),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_ERR    (PAR_ERR),
      .STP_ERR    (STP_ERR)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int         edge_n;
      bit         v, pe, se;
      logic [7:0] d;
   } ev_t;

   ev_t        q[$];
   ev_t        e;
   int         tests = 0, fails = 0;
   logic [7:0] exp_pdata = 8'h00;
   bit         ev_v, ev_pe, ev_se;
   int         last_v = -1, prev_v = -1, last_pe = -1, last_se = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Outputs seen at the negedge before posedge k are what edge k captures, so an event for edge k is due at cyc+1 == k.
   always @(negedge clk) begin
      if (reset) begin
         exp_pdata = 8'h00;
         q.delete();
         check("reset_outputs", {21'd0, DATA_VALID, PAR_ERR, STP_ERR, P_DATA}, 32'd0);
      end else begin
         ev_v = 1'b0; ev_pe = 1'b0; ev_se = 1'b0;
         if (q.size() > 0 && q[0].edge_n == cyc + 1) begin
            e = q.pop_front();
            ev_v = e.v; ev_pe = e.pe; ev_se = e.se;
            if (e.v) exp_pdata = e.d;
         end
         check("pulses{dv,pe,se}", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, {29'd0, ev_v, ev_pe, ev_se});
         check("p_data", {24'd0, P_DATA}, {24'd0, exp_pdata});
         if (DATA_VALID) begin prev_v = last_v; last_v = cyc + 1; end
         if (PAR_ERR) last_pe = cyc + 1;
         if (STP_ERR) last_se = cyc + 1;
      end
   end

   // Drives one frame starting just after a posedge; edge 0 (t0) is the next posedge.
   task automatic send_frame(input int p, input logic [5:0] p_in, input logic en, input logic typ,
                             input logic [7:0] d, input logic flip_par, input logic stopb,
                             input int gap, output int t0);
      ev_t  ne;
      logic parb;
      int   n;
      parb = (^d) ^ typ ^ flip_par;
      n    = 10 + int'(en);
      PRESCALE = p_in; PAR_EN = en; PAR_TYP = typ;
      t0 = cyc + 1;
      ne.edge_n = t0 + 3 + n * p;
      ne.pe     = en && (((^d) ^ typ) != parb);
      ne.se     = !stopb;
      ne.v      = !ne.pe && !ne.se;
      ne.d      = d;
      q.push_back(ne);
      RX_IN = 1'b0;
      repeat (p) @(posedge clk); #1;
      PRESCALE = 6'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
      for (int i = 0; i < 8; i++) begin
         RX_IN = d[i];
         repeat (p) @(posedge clk); #1;
      end
      if (en) begin
         RX_IN = parb;
         repeat (p) @(posedge clk); #1;
      end
      RX_IN = stopb;
      repeat (p) @(posedge clk); #1;
      RX_IN = 1'b1;
      if (gap > 0) begin
         repeat (gap) @(posedge clk); #1;
      end
   endtask

   int t0, t1, p, gap, sel;
   logic [5:0] p_in;
   logic en, typ, flip, stopb;
   logic [7:0] d;
   int v_before;

   initial begin
      reset = 1'b1; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      repeat (3) @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk); #1;
      check("post_reset_pdata", {24'd0, P_DATA}, 32'h0);

      send_frame(8, 6'd8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 10, t0);
      check("even_par_valid_edge", last_v, t0 + 91);
      check("even_par_data", {24'd0, P_DATA}, 32'hA5);
      v_before = last_v;

      send_frame(16, 6'd16, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 10, t0);
      check("odd_par_err_edge", last_pe, t0 + 179);
      check("par_err_no_valid", last_v, v_before);
      check("par_err_holds_data", {24'd0, P_DATA}, 32'hA5);

      send_frame(8, 6'd8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 80, t0);
      check("stop_err_edge", last_se, t0 + 83);
      check("stop_err_no_valid", last_v, v_before);

      PRESCALE = 6'd8; PAR_EN = 1'b0;
      RX_IN = 1'b0;
      repeat (3) @(posedge clk); #1;
      RX_IN = 1'b1;
      repeat (8) @(posedge clk); #1;
      check("glitch_no_valid", last_v, v_before);
      send_frame(8, 6'd8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 10, t0);
      check("after_glitch_edge", last_v, t0 + 83);
      check("after_glitch_data", {24'd0, P_DATA}, 32'h5A);

      send_frame(32, 6'd32, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 0, t0);
      send_frame(32, 6'd32, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 10, t1);
      check("b2b_spacing", last_v - prev_v, 320);
      check("b2b_first_edge", prev_v, t0 + 323);
      check("b2b_data", {24'd0, P_DATA}, 32'hAA);

      send_frame(8, 6'd12, 1'b1, 1'b0, 8'h6E, 1'b0, 1'b1, 10, t0);
      check("illegal_prescale_edge", last_v, t0 + 91);
      check("illegal_prescale_data", {24'd0, P_DATA}, 32'h6E);

      PRESCALE = 6'd16; PAR_EN = 1'b0;
      RX_IN = 1'b0;
      repeat (48) @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("reset_immediate", {21'd0, DATA_VALID, PAR_ERR, STP_ERR, P_DATA}, 32'd0);
      RX_IN = 1'b1;
      repeat (4) @(posedge clk); #1;
      reset = 1'b0;
      repeat (4) @(posedge clk); #1;
      send_frame(16, 6'd16, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 10, t0);
      check("after_reset_edge", last_v, t0 + 163);
      check("after_reset_data", {24'd0, P_DATA}, 32'hC3);

      for (int k = 0; k < 40; k++) begin
         sel = int'($urandom_range(0, 2));
         p   = (sel == 0) ? 8 : (sel == 1) ? 16 : 32;
         p_in = 6'(p);
         if (p == 8 && $urandom_range(0, 3) == 0) begin
            sel  = int'($urandom_range(0, 3));
            p_in = (sel == 0) ? 6'd0 : (sel == 1) ? 6'd12 : (sel == 2) ? 6'd63 : 6'd20;
         end
         en    = 1'($urandom);
         typ   = 1'($urandom);
         d     = 8'($urandom);
         flip  = ($urandom_range(0, 4) == 0);
         stopb = ($urandom_range(0, 5) != 0);
         gap   = stopb ? int'($urandom_range(0, 20)) : 80;
         send_frame(p, p_in, en, typ, d, flip, stopb, gap, t0);
      end

      repeat (100) @(posedge clk); #1;
      check("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
